c64_bus_decode: RTL

C64_BUS_DECODE -- requirements
Module: c64_bus_decode

---
 rtl/c64_bus_decode_if.sv | 12 +
 rtl/c64_bus_decode.sv | 137 +++++++++++++
 2 files changed

// File: rtl/c64_bus_decode_if.sv
// CPU-side bus between the 6510 wrapper and the C64 address decoder.
// The wrapper drives address, write data and strobes; the decoder returns read data.
interface c64_bus_decode_if;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        rdy;
    logic [7:0]  cpu_di;

    modport master (output cpu_ab, output cpu_do, output cpu_we, output rdy, input cpu_di);
    modport slave  (input cpu_ab, input cpu_do, input cpu_we, input rdy, output cpu_di);
endinterface

// File: rtl/c64_bus_decode.sv
// C64 memory map decoder with the 6510 on-chip I/O port ($0000/$0001).
// Read data reaches the CPU exactly one cycle after the address, via a registered source select.
module c64_bus_decode (
    input  logic                    clk,
    input  logic                    reset,
    c64_bus_decode_if.slave         cpu,
    output logic [15:0]             ram_addr,
    output logic                    ram_we,
    output logic [7:0]              ram_do,
    input  logic [7:0]              ram_di,
    output logic [12:0]             rom_addr,
    output logic [1:0]              rom_sel,
    input  logic [7:0]              rom_di,
    output logic [11:0]             io_addr,
    output logic                    io_re,
    output logic                    io_we,
    output logic [7:0]              io_do,
    input  logic [7:0]              io_di,
    input  logic                    cass_sense,
    output logic                    cass_wr,
    output logic                    cass_motor,
    output logic [2:0]              bank
);
    localparam logic [1:0] SEL_RAM = 2'd0;
    localparam logic [1:0] SEL_ROM = 2'd1;
    localparam logic [1:0] SEL_IO  = 2'd2;
    localparam logic [1:0] SEL_REG = 2'd3;

    localparam logic [1:0] ROM_BASIC  = 2'd0;
    localparam logic [1:0] ROM_KERNAL = 2'd1;
    localparam logic [1:0] ROM_CHAR   = 2'd2;

    logic [7:0] ddr_reg, port_reg, hold_reg;
    logic [1:0] sel_reg, sel_next;
    logic [7:0] pull_level, eff;
    logic       loram, hiram, charen;
    logic       is_ddr, is_port, in_basic, in_kernal, in_io_win;
    logic       basic_vis, kernal_vis, io_vis, char_vis, active;
    logic [7:0] reg_rd_val, di_mux;

    // Undriven port lines float to the board pull level; bit 4 follows the cassette switch.
    assign pull_level = {2'b00, 1'b1, cass_sense, 4'b1111};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign eff[gi] = ddr_reg[gi] ? port_reg[gi] : pull_level[gi];
        end
    endgenerate

    assign loram      = eff[0];
    assign hiram      = eff[1];
    assign charen     = eff[2];
    assign bank       = {charen, hiram, loram};
    assign cass_wr    = eff[3];
    assign cass_motor = eff[5];

    assign is_ddr    = (cpu.cpu_ab == 16'h0000);
    assign is_port   = (cpu.cpu_ab == 16'h0001);
    assign in_basic  = (cpu.cpu_ab[15:13] == 3'b101);
    assign in_kernal = (cpu.cpu_ab[15:13] == 3'b111);
    assign in_io_win = (cpu.cpu_ab[15:12] == 4'hD);

    // Visibility uses the registers as they stand, so a port write only affects later cycles.
    assign basic_vis  = in_basic & loram & hiram;
    assign kernal_vis = in_kernal & hiram;
    assign io_vis     = in_io_win & (loram | hiram) & charen;
    assign char_vis   = in_io_win & (loram | hiram) & ~charen;

    assign ram_addr = cpu.cpu_ab;
    assign ram_do   = cpu.cpu_do;
    assign io_do    = cpu.cpu_do;
    assign io_addr  = cpu.cpu_ab[11:0];

    always_comb begin
        sel_next = SEL_RAM;
        rom_sel  = ROM_BASIC;
        rom_addr = cpu.cpu_ab[12:0];
        if (is_ddr || is_port) begin
            sel_next = SEL_REG;
        end else if (basic_vis) begin
            sel_next = SEL_ROM;
        end else if (kernal_vis) begin
            sel_next = SEL_ROM;
            rom_sel  = ROM_KERNAL;
        end else if (io_vis) begin
            sel_next = SEL_IO;
        end else if (char_vis) begin
            sel_next = SEL_ROM;
            rom_sel  = ROM_CHAR;
            rom_addr = {1'b0, cpu.cpu_ab[11:0]};
        end
    end

    // Strobes are suppressed while paused or in reset; writes under ROM land in RAM.
    assign active = reset & cpu.rdy;
    assign ram_we = active & cpu.cpu_we & ~io_vis;
    assign io_we  = active & cpu.cpu_we & io_vis;
    assign io_re  = active & ~cpu.cpu_we & io_vis;

    assign reg_rd_val = is_ddr ? ddr_reg : eff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ddr_reg  <= 8'h00;
            port_reg <= 8'h00;
            hold_reg <= 8'h00;
            sel_reg  <= SEL_RAM;
        end else if (cpu.rdy) begin
            if (cpu.cpu_we) begin
                sel_reg <= SEL_RAM;
                if (is_ddr) begin
                    ddr_reg <= cpu.cpu_do;
                end
                if (is_port) begin
                    port_reg <= cpu.cpu_do;
                end
            end else begin
                sel_reg <= sel_next;
                if (is_ddr || is_port) begin
                    hold_reg <= reg_rd_val;
                end
            end
        end
    end

    always_comb begin
        case (sel_reg)
            SEL_ROM: di_mux = rom_di;
            SEL_IO:  di_mux = io_di;
            SEL_REG: di_mux = hold_reg;
            default: di_mux = ram_di;
        endcase
    end

    assign cpu.cpu_di = di_mux;
endmodule
